// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants and helpers for the register write arbiter.
// Default geometry lives here so every file agrees on it.
package reg_write_arbiter_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int NREQ_DEF  = 4;
    localparam int NREGS_DEF = 8;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first eligible requester after last_grant,
// wrapping around, so a held request is served within NREQ grants.
module rr_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int GW   = 2
) (
    input  logic [NREQ-1:0] req_eligible,
    input  logic [GW-1:0]   last_grant,
    output logic [NREQ-1:0] grant_onehot,
    output logic [GW-1:0]   grant_idx,
    output logic            grant_valid
);

    int cand;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the tool infers a latch to hold it.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        grant_valid  = 1'b0;
        cand         = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_grant) + k) % NREQ;
            if (!grant_valid && req_eligible[cand]) begin
                grant_valid        = 1'b1;
                grant_idx          = GW'(cand);
                grant_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Register file with NREQ round-robin arbitrated write ports and one
// combinational read port; each committed write is confirmed by an ack pulse.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int  WIDTH = WIDTH_DEF,
    parameter int  NREQ  = NREQ_DEF,
    parameter int  NREGS = NREGS_DEF,
    localparam int AW    = clog2(NREGS),
    localparam int GW    = (clog2(NREQ) > 0) ? clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*AW-1:0]    wr_addr,
    input  logic [NREQ*WIDTH-1:0] wr_data,
    output logic [NREQ-1:0]       ack,
    input  logic [AW-1:0]         rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    output logic [GW-1:0]         last_grant
);

    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  grant_onehot;
    logic [GW-1:0]    grant_idx;
    logic             grant_valid;
    logic [AW-1:0]    grant_addr;
    logic [WIDTH-1:0] grant_data;

    logic [NREQ-1:0]  ack_q, ack_d;
    logic [GW-1:0]    last_grant_q, last_grant_d;
    logic [WIDTH-1:0] regs_q [NREGS];

    // A requester whose ack is high this cycle is finishing, not asking again.
    assign eligible = req & ~ack_q;

    rr_arbiter #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_rr_arbiter (
        .req_eligible (eligible),
        .last_grant   (last_grant_q),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .grant_valid  (grant_valid)
    );

    assign grant_addr = wr_addr[int'(grant_idx)*AW +: AW];
    assign grant_data = wr_data[int'(grant_idx)*WIDTH +: WIDTH];

    always_comb begin
        ack_d        = grant_onehot;
        last_grant_d = grant_valid ? grant_idx : last_grant_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q        <= '0;
            last_grant_q <= GW'(NREQ - 1);
        end else begin
            ack_q        <= ack_d;
            last_grant_q <= last_grant_d;
        end
    end

    // NOTE: the register file is built from individually reset flops rather
    // than a RAM macro, because its contents must read as zero after reset.
    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                regs_q[r] <= '0;
            end else if (grant_valid && (grant_addr == AW'(r))) begin
                regs_q[r] <= grant_data;
            end
        end
    end

    assign rd_data    = regs_q[rd_addr];
    assign ack        = ack_q;
    assign last_grant = last_grant_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: inputs change and outputs are sampled
// 1 time unit after each rising edge, well away from the next edge.
module tb_reg_write_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int NREGS = 8;
    localparam int AW    = 3;
    localparam int GW    = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*AW-1:0]    wr_addr;
    logic [NREQ*WIDTH-1:0] wr_data;
    logic [NREQ-1:0]       ack;
    logic [AW-1:0]         rd_addr;
    logic [WIDTH-1:0]      rd_data;
    logic [GW-1:0]         last_grant;

    int checks = 0;
    int errors = 0;

    reg_write_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .NREGS (NREGS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .ack        (ack),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .last_grant (last_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int i, input logic [AW-1:0] addr,
                            input logic [WIDTH-1:0] data);
        wr_addr[i*AW +: AW]       = addr;
        wr_data[i*WIDTH +: WIDTH] = data;
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] addr,
                              input logic [WIDTH-1:0] expected);
        rd_addr = addr;
        #0.1;
        check(tag, 32'(rd_data), 32'(expected));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [GW-1:0] exp_g;

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;

        // Reset then idle
        do_reset();
        step();
        check("reset_ack", 32'(ack), 32'h0);
        check("reset_last_grant", 32'(last_grant), 32'd3);
        for (int a = 0; a < NREGS; a++) begin
            read_check($sformatf("reset_rd%0d", a), AW'(a), 8'h00);
        end

        // Single write from requester 2
        set_port(2, 3'd5, 8'hA5);
        req = 4'b0100;
        step();
        check("single_ack", 32'(ack), 32'b0100);
        check("single_last_grant", 32'(last_grant), 32'd2);
        read_check("single_rd5", 3'd5, 8'hA5);
        req = '0;
        step();
        check("single_ack_pulse_ends", 32'(ack), 32'h0);

        // Full load from a fresh reset: order 0,1,2,3,0,1,2,3
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_port(i, AW'(i), 8'(8'h10 + i));
        end
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            step();
            exp_g = GW'(c % NREQ);
            check($sformatf("load_ack_c%0d", c), 32'(ack), 32'(1 << exp_g));
            check($sformatf("load_grant_c%0d", c), 32'(last_grant), 32'(exp_g));
        end
        req = '0;
        step();
        check("load_idle_ack", 32'(ack), 32'h0);
        for (int i = 0; i < NREQ; i++) begin
            read_check($sformatf("load_rd%0d", i), AW'(i), 8'(8'h10 + i));
        end

        // Same address from requesters 0 and 1; last_grant is 3 so 0 goes first
        set_port(0, 3'd3, 8'h11);
        set_port(1, 3'd3, 8'h22);
        req = 4'b0011;
        step();
        check("same_ack0", 32'(ack), 32'b0001);
        read_check("same_rd3_first", 3'd3, 8'h11);
        req = 4'b0010;
        step();
        check("same_ack1", 32'(ack), 32'b0010);
        read_check("same_rd3_final", 3'd3, 8'h22);
        req = '0;
        step();

        // Read/write collision on address 4
        rd_addr = 3'd4;
        set_port(1, 3'd4, 8'h7F);
        req = 4'b0010;
        read_check("collide_before", 3'd4, 8'h00);
        step();
        check("collide_ack", 32'(ack), 32'b0010);
        read_check("collide_after", 3'd4, 8'h7F);
        req = '0;
        step();

        // Reset mid-cycle with requesters 1 and 2 pending
        set_port(1, 3'd6, 8'h66);
        set_port(2, 3'd7, 8'h77);
        req     = 4'b0110;
        rd_addr = 3'd4;
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_rd4_cleared", 32'(rd_data), 32'h0);
        check("midrst_ack", 32'(ack), 32'h0);
        check("midrst_last_grant", 32'(last_grant), 32'd3);
        step();
        check("midrst_ack_held", 32'(ack), 32'h0);
        read_check("midrst_rd6", 3'd6, 8'h00);
        rst_n = 1'b1;
        step();
        check("post_rst_ack1", 32'(ack), 32'b0010);
        check("post_rst_grant1", 32'(last_grant), 32'd1);
        req = 4'b0100;
        step();
        check("post_rst_ack2", 32'(ack), 32'b0100);
        check("post_rst_grant2", 32'(last_grant), 32'd2);
        req = '0;
        read_check("post_rst_rd6", 3'd6, 8'h66);
        read_check("post_rst_rd7", 3'd7, 8'h77);
        step();
        check("post_rst_idle_ack", 32'(ack), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data width of each register and write port.
REQ-002 The block SHALL have parameter NREQ, default 4, meaning the number of write requesters.
REQ-003 The block SHALL have parameter NREGS, default 8, meaning the register count; it is a power of two with AW = log2(NREGS).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, all state updates on posedge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req, input, NREQ bits: per-requester write request, held high until acked.
REQ-007 The block SHALL have port wr_addr, input, NREQ*AW bits: packed per-requester target address, slice i belongs to requester i.
REQ-008 The block SHALL have port wr_data, input, NREQ*WIDTH bits: packed per-requester write data.
REQ-009 The block SHALL have port ack, output, NREQ bits: registered one-cycle pulse confirming the write is committed.
REQ-010 The block SHALL have port rd_addr, input, AW bits: read address.
REQ-011 The block SHALL have port rd_data, output, WIDTH bits: combinational read of register rd_addr.
REQ-012 The block SHALL have port last_grant, output, log2(NREQ) bits: index of the most recent granted requester.

Function
REQ-013 Each cycle, eligible requesters SHALL be those with req[i]=1 and ack[i]=0, so a requester being acked is not re-granted in the same cycle.
REQ-014 Arbitration SHALL be round-robin, searching eligible requesters starting at index (last_grant+1) mod NREQ and choosing the first found.
REQ-015 On the posedge where a grant g exists, register[wr_addr_g] SHALL load wr_data_g, ack SHALL become one-hot bit g for exactly one cycle, and last_grant SHALL become g.
REQ-016 With no eligible requester, registers and last_grant SHALL hold and ack SHALL be all zero.
REQ-017 Write latency SHALL be 1 cycle from grant to data visible on rd_data and ack high; at most one register is written per cycle.
REQ-018 When a requester samples ack[i]=1, it SHALL treat the write as done; if req[i] is still high in the following cycle, that is a new request.
REQ-019 When the read and write address match in the same cycle, rd_data SHALL show the old value until the edge and the new value after it, with no bypass.
REQ-020 When several requesters target the same address, writes SHALL apply in grant order; the last granted value wins.
REQ-021 For a sustained full load, each requester SHALL be granted at least once every NREQ cycles, with no starvation.

Reset
REQ-022 When rst_n=0, asynchronously, all registers SHALL be 0, ack SHALL be 0, and last_grant SHALL be NREQ-1, so requester 0 has first priority.
REQ-023 A write in flight during reset SHALL be discarded with no ack; after deassert, requests are re-arbitrated from requester 0.

Structure
REQ-024 The shared package SHALL hold the default WIDTH/NREQ/NREGS constants and a clog2 helper function.
REQ-025 The round-robin logic SHALL live in sub-module rr_arbiter, with inputs req_eligible and last_grant and outputs grant_onehot, grant_idx and grant_valid.
REQ-026 Register storage SHALL be resettable enable-flops, one per register, with enable = grant_valid and decoded address.

Verification
REQ-027 Reset then idle: all ack=0, rd_data=0 for addresses 0..7, and last_grant=3.
REQ-028 Single write: req[2]=1 with addr 5 and data 0xA5 -> ack[2] pulses on the next edge only, reg5=0xA5, last_grant=2.
REQ-029 Full load: req=4'b1111, requesters held for 8 requests -> grants in the order 0,1,2,3,0,1,2,3, one per cycle, with acks matching.
REQ-030 Same address: req0 writes 0x11 and req1 writes 0x22 to addr 3 simultaneously -> after 2 cycles reg3=0x22.
REQ-031 Read/write collision: rd_addr=4 while req1 writes 0x7F to addr 4 -> rd_data shows the old value before the edge and 0x7F after it.
REQ-032 Mid-operation reset: rst_n pulsed low mid-cycle with req=4'b0110 -> registers go to 0 immediately and no ack; after release, grant order is 1 then 2.
